sysid_regs_ext: RTL
===================

Name: sysid_regs_ext

Overview:
- Parametrised successor to the fixed two-word system-ID slave: an Avalon-MM register slave with a registered, pipelined read path.
- Returns system ID, build timestamp and a capability word; adds a free-running 64-bit uptime counter with coherent snapshot, a control register and NUM_SCRATCH read/write scratch words with byte enables.
- Sits on the control interconnect; software uses it for ID checks, bus sanity tests and coarse time measurement.

Parameters:
- SYSTEM_ID, 32'h0000_0000, value returned at word 0.
- TIMESTAMP, 32'h0000_0000, build timestamp returned at word 1.
- VERSION, 8, block version, reported in CAPS[31:24].
- ADDR_W, 4, word-address width; must be ≥4.
- NUM_SCRATCH, 4, scratch words at 8..8+NUM_SCRATCH-1; range 0..(2^ADDR_W-8).
- SCRATCH_RESET, 32'h0000_0000, reset value of every scratch word.
- READ_LATENCY, 1, cycles from read acceptance to readdatavalid; range 1..3.
- TICK_DIV, 1, clocks per uptime increment; must be ≥1.

Ports:
- clock, input, 1, sole clock; all logic on rising edge.
- reset, input, 1, asynchronous, active-high reset.
- address, input, ADDR_W, word address.
- read, input, 1, read strobe; accepted every cycle it is high.
- write, input, 1, write strobe; accepted every cycle it is high.
- writedata, input, 32, write data.
- byteenable, input, 4, write byte lanes; ignored on reads.
- readdata, output, 32, read data; valid only with readdatavalid.
- readdatavalid, output, 1, one-cycle pulse per accepted read.

Behaviour:
- Reset (async assert, sync release): readdata=0, readdatavalid=0, read pipeline flushed, uptime=0, prescaler=0, shadow_hi=0, CONTROL=0, scratch=SCRATCH_RESET.
- No waitrequest; every strobe is accepted in its cycle.
- Register map (word addresses):
  - 0 SYSTEM_ID, read-only.
  - 1 TIMESTAMP, read-only.
  - 2 CAPS, read-only: [31:24]=VERSION, [23:16]=ADDR_W, [15:8]=READ_LATENCY, [7:0]=NUM_SCRATCH.
  - 3 UPTIME_LO, read-only.
  - 4 UPTIME_HI, read-only; returns shadow_hi.
  - 5 CONTROL, RW: bit0 CLEAR (write-1 pulse, reads 0); bit1 FREEZE (level).
  - 8.. scratch words, RW.
  - 6, 7 and unmapped addresses read 0 and ignore writes.
  - Writes to read-only words are ignored.
- Read pipeline:
  - Data is sampled at the acceptance edge and appears on readdata with readdatavalid exactly READ_LATENCY cycles later.
  - Back-to-back reads give back-to-back valids in order.
  - readdata holds its last value when readdatavalid=0.
- Uptime counter:
  - The prescaler counts 0..TICK_DIV-1; uptime increments on wrap; with TICK_DIV=1 it increments every clock.
  - FREEZE=1 halts both prescaler and uptime.
  - 64-bit uptime wraps from all-ones to 0 silently.
  - CLEAR zeros uptime and prescaler at that edge; clear wins over a simultaneous tick. FREEZE written in the same write takes effect from the next cycle.
- Snapshot:
  - A UPTIME_LO read returns the uptime low word as it stands before any increment at the acceptance edge.
  - The same edge loads shadow_hi with the matching high word, so LO-then-HI reads are coherent across a carry.
  - A UPTIME_HI read without a preceding LO read returns the stale shadow.
- Scratch: each byte lane updates only when byteenable[i]=1; byteenable=0 is a no-op.
- Read and write in the same cycle: both execute; the read returns the pre-write value.
- Reset mid-read: pending valids are discarded; no readdatavalid after reset release until a new read.

Test Plan:
- Reset, then read words 0, 1, 2 back-to-back (SYSTEM_ID=32'h5D30_1AB2, TIMESTAMP=32'h1234_5678, defaults) -> three consecutive valids at edges 1..3 after the first accept: 5D301AB2, 12345678, 08040104.
- READ_LATENCY=3, single read of word 0 -> readdatavalid exactly 3 cycles after accept; no other valid pulses.
- Scratch word 8: write FFFF_FFFF with be=1111, then write 0000_0000 with be=0101, read back -> FF00FF00; a be=0000 write leaves the value unchanged.
- Force uptime to 0000_0000_FFFF_FFFF (write CLEAR, then run 2^32-1 ticks, or via a bench-only preload), TICK_DIV=1, read LO on the carry edge then HI -> LO=FFFFFFFF, HI=00000000; the next LO/HI pair returns high word 1.
- TICK_DIV=4, FREEZE=1 for 10 clocks, then FREEZE=0 for 8 clocks -> uptime advances by exactly 2; CLEAR write -> next LO read returns 0 or 1 according to the elapsed ticks.
- Read word 6, write to word 0, and read and write scratch word 9 in the same cycle -> 0; SYSTEM_ID unchanged; old scratch value returned; reset asserted mid-pipeline -> readdatavalid=0 immediately and stays 0.

Source files
------------

// File: rtl/sysid_regs_ext.sv
// System-ID register slave: fixed ID/timestamp/capability words, 64-bit uptime
// counter with coherent LO/HI snapshot, control register and byte-enabled scratch words.
module sysid_regs_ext #(
    parameter logic [31:0] SYSTEM_ID     = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
    parameter int unsigned VERSION       = 8,
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned NUM_SCRATCH   = 4,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned TICK_DIV      = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    localparam int unsigned REG_SYSID     = 0;
    localparam int unsigned REG_TIMESTAMP = 1;
    localparam int unsigned REG_CAPS      = 2;
    localparam int unsigned REG_UP_LO     = 3;
    localparam int unsigned REG_UP_HI     = 4;
    localparam int unsigned REG_CONTROL   = 5;
    localparam int unsigned SCR_BASE      = 8;

    localparam int unsigned SCR_N     = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;
    localparam int unsigned SCR_IDX_W = (SCR_N > 1) ? $clog2(SCR_N) : 1;
    localparam int unsigned PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [31:0]      CAPS_WORD = {8'(VERSION), 8'(ADDR_W), 8'(READ_LATENCY), 8'(NUM_SCRATCH)};
    localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(TICK_DIV - 1);

    logic [31:0]          addr_w;
    logic                 scr_hit;
    logic [SCR_IDX_W-1:0] scr_idx;
    logic [31:0]          rd_word;
    logic                 wr_ctrl;
    logic                 do_clear;

    logic [PRE_W-1:0]     prescaler;
    logic [63:0]          uptime;
    logic [31:0]          shadow_hi;
    logic                 freeze;
    logic [31:0]          scratch [SCR_N];

    logic [31:0]             pipe_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_vld;

    // Address decode shared by the read mux and the write side
    always_comb begin
        addr_w   = 32'(address);
        scr_hit  = (addr_w >= SCR_BASE) && (addr_w < SCR_BASE + NUM_SCRATCH);
        scr_idx  = SCR_IDX_W'(addr_w - SCR_BASE);
        wr_ctrl  = write && (addr_w == REG_CONTROL) && byteenable[0];
        do_clear = wr_ctrl && writedata[0];
    end

    // Read mux sees pre-edge state, so a read colliding with a write returns the old value
    always_comb begin
        rd_word = '0;
        case (addr_w)
            REG_SYSID:     rd_word = SYSTEM_ID;
            REG_TIMESTAMP: rd_word = TIMESTAMP;
            REG_CAPS:      rd_word = CAPS_WORD;
            REG_UP_LO:     rd_word = uptime[31:0];
            REG_UP_HI:     rd_word = shadow_hi;
            REG_CONTROL:   rd_word = {30'd0, freeze, 1'b0};
            default: begin
                if (scr_hit) rd_word = scratch[scr_idx];
            end
        endcase
    end

    // Prescaled uptime counter; clear beats a simultaneous tick, freeze halts both
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            uptime    <= '0;
            freeze    <= 1'b0;
        end else begin
            if (do_clear) begin
                prescaler <= '0;
                uptime    <= '0;
            end else if (!freeze) begin
                if (prescaler == PRE_MAX) begin
                    prescaler <= '0;
                    uptime    <= uptime + 64'd1;
                end else begin
                    prescaler <= prescaler + PRE_W'(1);
                end
            end
            if (wr_ctrl) freeze <= writedata[1];
        end
    end

    // High word captured alongside every LO read for a coherent 64-bit pair
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_hi <= '0;
        end else if (read && (addr_w == REG_UP_LO)) begin
            shadow_hi <= uptime[63:32];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SCR_N; i++) scratch[i] <= SCRATCH_RESET;
        end else if (write && scr_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) scratch[scr_idx][8*b +: 8] <= writedata[8*b +: 8];
            end
        end
    end

    // Each stage loads only on a valid entry, so the last stage holds its data between reads
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pipe_data[i] <= '0;
        end else begin
            pipe_vld[0] <= read;
            if (read) pipe_data[0] <= rd_word;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    assign readdata      = pipe_data[READ_LATENCY-1];
    assign readdatavalid = pipe_vld[READ_LATENCY-1];

endmodule
